pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage LEGv8 pipeline. It drives the write-enable, bubble and flush inputs of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Detects load-use hazards from the IF/ID instruction and the ID/EX destination register.
- Squashes wrong-path instructions on a taken branch resolved in MEM.
- Freezes the whole pipeline while a multi-cycle data memory is not ready. A timeout watchdog traps into an error state.

Parameters:
- MEM_TIMEOUT, 255: maximum consecutive dmem wait cycles before an error trap.
- TO_W, 8: width of the wait counter; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
- clock  in  1  pipeline clock; all state updates on the falling edge, the same edge on which the pipeline registers latch.
- reset  in  1  asynchronous, active-high.
- if_id_instr  in  32  instruction currently in ID.
- id_ex_memread  in  1  ID/EX Memread.
- id_ex_write_reg  in  5  ID/EX write_reg (Rt/Rd).
- ex_mem_branch_taken  in  1  (Branch & zero) | Uncond_Branch from EX/MEM.
- dmem_req  in  1  EX/MEM Memread | Memwrite.
- dmem_ready  in  1  data memory has completed the access this cycle.
- pc_write  out  1  PC load enable.
- if_id_write  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID loads zero (NOP).
- id_ex_bubble  out  1  ID/EX control fields load zero.
- id_ex_flush  out  1  ID/EX loads all zero.
- ex_mem_flush  out  1  EX/MEM control fields load zero.
- pipe_hold  out  1  ID/EX, EX/MEM and MEM/WB hold their contents.
- mem_error  out  1  sticky timeout flag.
- state  out  2  current state: RUN=0, MEM_WAIT=1, FLUSH=2, ERROR=3.
- stall_cycles  out  32  performance counter (see Optional Feature).
- flush_count  out  32  performance counter (see Optional Feature).

Behaviour:
- Reset: state=RUN, wait counter=0, mem_error=0, counters=0. While reset is high, all outputs are forced to: pc_write=0, if_id_write=0, flushes=0, bubble=0, pipe_hold=1.
- Source decode from if_id_instr:
  - Rn=[9:5] is always a source.
  - Rm=[20:16] is a source for R-format opcodes ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
  - Rt=[4:0] is a source for STUR 11111000000 and for CBZ ([31:24]=10110100).
- load_use = id_ex_memread & (id_ex_write_reg != 31) & (id_ex_write_reg matches any active source register).
- Combinational outputs are evaluated in priority order; the first match wins:
  1. state==ERROR: pc_write=0, if_id_write=0, pipe_hold=1.
  2. dmem_req & !dmem_ready: pc_write=0, if_id_write=0, pipe_hold=1. Branch and load-use are ignored this cycle.
  3. ex_mem_branch_taken: pc_write=1, if_id_flush=1, id_ex_flush=1, ex_mem_flush=1.
  4. load_use: pc_write=0, if_id_write=0, id_ex_bubble=1.
  5. Otherwise: pc_write=1, if_id_write=1, all other outputs 0.
- State transitions (falling edge):
  - RUN -> MEM_WAIT on condition 2; the wait counter loads 1.
  - RUN -> FLUSH on condition 3.
  - Otherwise the state stays in RUN.
  - MEM_WAIT: the counter increments each cycle while not ready.
    - Returns to RUN on dmem_ready and clears the counter.
    - A branch pending in EX/MEM is honoured on the first cycle after return, because condition 3 is re-evaluated.
    - If the counter reaches MEM_TIMEOUT while still not ready: go to ERROR and set mem_error=1.
  - FLUSH: lasts exactly 1 cycle; outputs follow the priority list. Returns to RUN, or goes to MEM_WAIT if condition 2 holds.
  - ERROR: absorbing; exited only by reset.
- Load-use needs no state: after one bubble, ID/EX holds memread=0 and the hazard clears naturally. Exactly one stall cycle results per load-use pair.
- A load-use and a taken branch in the same cycle resolve as flush only (no bubble); the dependent instruction is squashed.
- Reset asserted mid-MEM_WAIT or in ERROR returns to RUN immediately (asynchronously).

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cycles increments on each cycle in which pc_write=0 and reset is low.
  - flush_count increments on each cycle in which ex_mem_flush=1.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and clear on reset.
- Undefined: both ports are present but tied to 0, and no counter flops are synthesized.

Test Plan:
- LDUR X2,[X1,#0] in ID/EX (write_reg=2, memread=1), IF/ID holds ADD X3,X2,X4 -> one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1; next cycle all enables=1.
- Same as above but the load targets X31 -> no stall.
- Load X5 with IF/ID holding STUR X5,[X6] (Rt=5) -> stall. With IF/ID holding SUB X7,X8,X9 -> no stall.
- ex_mem_branch_taken=1 in RUN -> if_id_flush, id_ex_flush and ex_mem_flush all 1 for one cycle, state=2 for one cycle, then state=0; flush_count=1 with the macro defined.
- dmem_req=1 with dmem_ready low for 3 cycles -> pipe_hold=1 and pc_write=0 for 3 cycles, state=1, then RUN; stall_cycles=3.
- dmem_ready held low for 255 cycles -> state=3, mem_error=1 and sticky; a reset pulse then gives state=0 and mem_error=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage LEGv8 pipeline: load-use bubbles, branch squash, dmem freeze with timeout trap.
// Define HAZARD_PERF_CNT_EN to build the stall_cycles / flush_count performance counters.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] if_id_instr,
  input  logic        id_ex_memread,
  input  logic [4:0]  id_ex_write_reg,
  input  logic        ex_mem_branch_taken,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        pipe_hold,
  output logic        mem_error,
  output logic [1:0]  state,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2,
    ERROR    = 2'd3
  } state_e;

  localparam logic [TO_W-1:0] TIMEOUT_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [TO_W-1:0] waitCnt_q, waitCnt_d;
  logic            memError_q, memError_d;

  logic [10:0] opcode;
  logic [4:0]  rn, rm, rt;
  logic        useRm, useRt, loadUse, memStall;
  logic        unusedInstrBits;

  assign opcode = if_id_instr[31:21];
  assign rm     = if_id_instr[20:16];
  assign rn     = if_id_instr[9:5];
  assign rt     = if_id_instr[4:0];
  assign unusedInstrBits = ^if_id_instr[15:10];

  assign useRm = (opcode == 11'b10001011000) || (opcode == 11'b11001011000) ||
                 (opcode == 11'b10001010000) || (opcode == 11'b10101010000);
  assign useRt = (opcode == 11'b11111000000) || (if_id_instr[31:24] == 8'b10110100);

  // X31 is the zero register, so a load targeting it can never feed a consumer.
  assign loadUse = id_ex_memread && (id_ex_write_reg != 5'd31) &&
                   ((id_ex_write_reg == rn) ||
                    (useRm && (id_ex_write_reg == rm)) ||
                    (useRt && (id_ex_write_reg == rt)));

  assign memStall = dmem_req && !dmem_ready;

  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    pipe_hold    = 1'b0;
    if (reset) begin
      pipe_hold = 1'b1;
    end else if (state_q == ERROR || memStall) begin
      pipe_hold = 1'b1;
    end else if (ex_mem_branch_taken) begin
      pc_write     = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (loadUse) begin
      id_ex_bubble = 1'b1;
    end else begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    waitCnt_d  = waitCnt_q;
    memError_d = memError_q;
    unique case (state_q)
      RUN, FLUSH: begin
        if (memStall) begin
          waitCnt_d = TO_W'(1);
          if (MEM_TIMEOUT <= 1) begin
            state_d    = ERROR;
            memError_d = 1'b1;
          end else begin
            state_d = MEM_WAIT;
          end
        end else if (state_q == RUN && ex_mem_branch_taken) begin
          state_d = FLUSH;
        end else begin
          state_d = RUN;
        end
      end
      MEM_WAIT: begin
        if (memStall) begin
          waitCnt_d = waitCnt_q + TO_W'(1);
          if (waitCnt_q >= TIMEOUT_LAST) begin
            state_d    = ERROR;
            memError_d = 1'b1;
          end
        end else begin
          state_d   = RUN;
          waitCnt_d = '0;
        end
      end
      default: state_d = ERROR;
    endcase
  end

  // Falling edge matches the edge on which the pipeline registers latch.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      waitCnt_q  <= '0;
      memError_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      memError_q <= memError_d;
    end
  end

  assign state     = state_q;
  assign mem_error = memError_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stallCnt_q, flushCnt_q;

  // Both counters saturate rather than wrap so long runs stay meaningful.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      if (!pc_write && stallCnt_q != 32'hFFFF_FFFF) stallCnt_q <= stallCnt_q + 32'd1;
      if (ex_mem_flush && flushCnt_q != 32'hFFFF_FFFF) flushCnt_q <= flushCnt_q + 32'd1;
    end
  end

  assign stall_cycles = stallCnt_q;
  assign flush_count  = flushCnt_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 32'd0;
`endif

endmodule
